// File: rtl/gray_step_sequencer.sv
// Command-driven up/down step counter with a Gray-coded view of its value.
// Accepts RUN/LOAD/CLEAR commands in IDLE and reports completion with one-cycle pulses.
module gray_step_sequencer #(
  parameter int WIDTH = 4,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic             cmd_dir,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             hold,
  input  logic             abort,
  output logic [WIDTH-1:0] bin_value,
  output logic [WIDTH-1:0] gray_count,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic             wrap,
  output logic             err
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [1:0]       OP_RUN   = 2'b00;
  localparam logic [1:0]       OP_LOAD  = 2'b01;
  localparam logic [1:0]       OP_CLEAR = 2'b10;
  localparam logic [WIDTH-1:0] VAL_ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] VAL_ZERO = '0;
  localparam logic [WIDTH-1:0] VAL_MAX  = '1;
  localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);
  localparam logic [LEN_W-1:0] LEN_ZERO = '0;

  state_t           state, state_n;
  logic [WIDTH-1:0] bin_n;
  logic [LEN_W-1:0] remaining, remaining_n;
  logic             dir, dir_n;
  logic             done_n, aborted_n, wrap_n, err_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      bin_value <= '0;
      remaining <= '0;
      dir       <= 1'b0;
      done      <= 1'b0;
      aborted   <= 1'b0;
      wrap      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_n;
      bin_value <= bin_n;
      remaining <= remaining_n;
      dir       <= dir_n;
      done      <= done_n;
      aborted   <= aborted_n;
      wrap      <= wrap_n;
      err       <= err_n;
    end
  end

  // Pulses are computed here and registered, so they appear the cycle after the deciding edge.
  always_comb begin
    state_n     = state;
    bin_n       = bin_value;
    remaining_n = remaining;
    dir_n       = dir;
    done_n      = 1'b0;
    aborted_n   = 1'b0;
    wrap_n      = 1'b0;
    err_n       = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          case (cmd_op)
            OP_RUN: begin
              if (cmd_len == LEN_ZERO) begin
                done_n = 1'b1;
              end else begin
                remaining_n = cmd_len;
                dir_n       = cmd_dir;
                state_n     = RUN;
              end
            end
            OP_LOAD: begin
              bin_n  = cmd_data;
              done_n = 1'b1;
            end
            OP_CLEAR: begin
              bin_n  = VAL_ZERO;
              done_n = 1'b1;
            end
            default: err_n = 1'b1;
          endcase
        end
      end
      RUN: begin
        // Abort wins over hold and suppresses the step on its edge.
        if (abort) begin
          state_n     = IDLE;
          remaining_n = LEN_ZERO;
          aborted_n   = 1'b1;
        end else if (!hold) begin
          if (dir) begin
            bin_n  = bin_value + VAL_ONE;
            wrap_n = (bin_value == VAL_MAX);
          end else begin
            bin_n  = bin_value - VAL_ONE;
            wrap_n = (bin_value == VAL_ZERO);
          end
          remaining_n = remaining - LEN_ONE;
          if (remaining == LEN_ONE) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign cmd_ready  = (state == IDLE);
  assign busy       = (state == RUN);
  assign gray_count = bin_value ^ (bin_value >> 1);

endmodule

// File: tb/tb_gray_step_sequencer.sv
// Self-checking bench for gray_step_sequencer: table vectors, directed corner
// sequences and randomized commands against a transaction-level reference model.
module tb_gray_step_sequencer;

  localparam int W   = 4;
  localparam int LW  = 8;
  localparam int MOD = 1 << W;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic          cmd_dir;
  logic [LW-1:0] cmd_len;
  logic [W-1:0]  cmd_data;
  logic          hold;
  logic          abort;
  logic [W-1:0]  bin_value;
  logic [W-1:0]  gray_count;
  logic          busy, done, aborted, wrap, err;

  int checks = 0;
  int errors = 0;

  gray_step_sequencer #(.WIDTH(W), .LEN_W(LW)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_dir(cmd_dir), .cmd_len(cmd_len), .cmd_data(cmd_data),
    .hold(hold), .abort(abort), .bin_value(bin_value), .gray_count(gray_count),
    .busy(busy), .done(done), .aborted(aborted), .wrap(wrap), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]    op;
    logic          dir;
    logic [LW-1:0] len;
    logic [W-1:0]  data;
    int            exp_bin;
    int            exp_done;
    int            exp_err;
  } vec_t;

  vec_t vecs[8];

  function automatic int gray_of(input int b);
    return (b ^ (b >> 1)) % MOD;
  endfunction

  function automatic int wrap_mod(input int v);
    return ((v % MOD) + MOD) % MOD;
  endfunction

  // Number of all-ones/zero crossings in s steps from start.
  function automatic int count_wraps(input int start, input int up, input int s);
    int first;
    first = up ? (MOD - start) : (start + 1);
    return (s >= first) ? ((s - first) / MOD + 1) : 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [1:0] op, input logic dir,
                                input int len, input int data);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_dir   = dir;
    cmd_len   = LW'(len);
    cmd_data  = W'(data);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic check_output(input string name, input int exp_bin, input int exp_done,
                              input int exp_err, input int exp_ab);
    check({name, "_bin"}, int'(bin_value), exp_bin);
    check({name, "_gray"}, int'(gray_count), gray_of(exp_bin));
    check({name, "_done"}, int'(done), exp_done);
    check({name, "_err"}, int'(err), exp_err);
    check({name, "_aborted"}, int'(aborted), exp_ab);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int mv, L, up, abort_at, unheld, cyc, wraps, steps, opsel, d;
    cmd_valid = 0; cmd_op = 0; cmd_dir = 0; cmd_len = 0; cmd_data = 0;
    hold = 0; abort = 0;
    rst_n = 0;
    #3;
    check("rst_bin", int'(bin_value), 0);
    check("rst_gray", int'(gray_count), 0);
    check("rst_ready", int'(cmd_ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_pulses", int'({done, aborted, err, wrap}), 0);
    tick(); tick();
    rst_n = 1;
    tick();

    vecs[0] = '{2'b01, 1'b0, 0, 5, 5, 1, 0};
    vecs[1] = '{2'b11, 1'b0, 0, 3, 5, 0, 1};
    vecs[2] = '{2'b00, 1'b1, 0, 0, 5, 1, 0};
    vecs[3] = '{2'b01, 1'b0, 0, 15, 15, 1, 0};
    vecs[4] = '{2'b10, 1'b0, 0, 7, 0, 1, 0};
    vecs[5] = '{2'b00, 1'b0, 0, 0, 0, 1, 0};
    vecs[6] = '{2'b11, 1'b1, 4, 9, 0, 0, 1};
    vecs[7] = '{2'b01, 1'b0, 0, 9, 9, 1, 0};
    foreach (vecs[i]) begin
      apply_stimulus(vecs[i].op, vecs[i].dir, int'(vecs[i].len), int'(vecs[i].data));
      check_output($sformatf("vec%0d", i), vecs[i].exp_bin, vecs[i].exp_done,
                   vecs[i].exp_err, 0);
      check($sformatf("vec%0d_ready", i), int'(cmd_ready), 1);
    end
    tick();
    check("vec_pulse_end", int'({done, err}), 0);

    // Full 16-step run up from zero.
    apply_stimulus(2'b10, 1'b0, 0, 0);
    apply_stimulus(2'b00, 1'b1, 16, 0);
    check("up16_busy", int'(busy), 1);
    check("up16_ready", int'(cmd_ready), 0);
    for (int k = 1; k <= 16; k++) begin
      tick();
      check($sformatf("up16_gray%0d", k), int'(gray_count), gray_of(k % MOD));
      check($sformatf("up16_wrap%0d", k), int'(wrap), (k == 16) ? 1 : 0);
      check($sformatf("up16_done%0d", k), int'(done), (k == 16) ? 1 : 0);
    end
    tick();
    check("up16_done_end", int'(done), 0);
    check("up16_busy_end", int'(busy), 0);

    // Down run across zero.
    apply_stimulus(2'b01, 1'b0, 0, 1);
    apply_stimulus(2'b00, 1'b0, 3, 0);
    tick(); check("dn_b0", int'(bin_value), 0);  check("dn_w0", int'(wrap), 0);
    tick(); check("dn_b1", int'(bin_value), 15); check("dn_w1", int'(wrap), 1);
    tick(); check("dn_b2", int'(bin_value), 14); check("dn_w2", int'(wrap), 0);
    check("dn_done", int'(done), 1);
    check("dn_gray", int'(gray_count), 9);

    // Two held edges stretch a 5-step run to 7 cycles.
    apply_stimulus(2'b00, 1'b1, 5, 0);
    for (int c = 1; c <= 7; c++) begin
      hold = (c == 3 || c == 4);
      tick();
      check($sformatf("hold_done%0d", c), int'(done), (c == 7) ? 1 : 0);
    end
    hold = 0;
    check("hold_bin", int'(bin_value), 3);

    // Abort after three steps, then abort while idle.
    apply_stimulus(2'b01, 1'b0, 0, 6);
    apply_stimulus(2'b00, 1'b1, 10, 0);
    tick(); tick(); tick();
    abort = 1; hold = 1;
    tick();
    abort = 0; hold = 0;
    check_output("abort", 9, 0, 0, 1);
    check("abort_ready", int'(cmd_ready), 1);
    tick();
    check_output("abort_after", 9, 0, 0, 0);
    abort = 1;
    tick();
    abort = 0;
    check_output("abort_idle", 9, 0, 0, 0);

    // A command offered during RUN stays pending and is taken once idle.
    cmd_valid = 1; cmd_op = 2'b00; cmd_dir = 1; cmd_len = 2;
    tick();
    cmd_op = 2'b01; cmd_data = 7;
    tick(); check("pend_b1", int'(bin_value), 10); check("pend_busy", int'(busy), 1);
    tick(); check("pend_b2", int'(bin_value), 11); check("pend_done1", int'(done), 1);
    tick(); check("pend_load", int'(bin_value), 7); check("pend_done2", int'(done), 1);
    cmd_valid = 0;

    // Asynchronous reset in the middle of a run.
    apply_stimulus(2'b00, 1'b1, 8, 0);
    tick(); tick();
    #2 rst_n = 0;
    #1;
    check("arst_bin", int'(bin_value), 0);
    check("arst_busy", int'(busy), 0);
    check("arst_ready", int'(cmd_ready), 1);
    check("arst_pulses", int'({done, aborted, wrap, err}), 0);
    tick();
    rst_n = 1;
    tick();
    check_output("arst_rel", 0, 0, 0, 0);
    apply_stimulus(2'b01, 1'b0, 0, 3);
    check_output("arst_load", 3, 1, 0, 0);

    // Randomized commands against a transaction-level model.
    mv = 3;
    for (int t = 0; t < 40; t++) begin
      opsel = $urandom_range(0, 9);
      if (opsel < 6) begin
        L = $urandom_range(0, 40);
        up = $urandom_range(0, 1);
        abort_at = ($urandom_range(0, 3) == 0 && L > 1) ? $urandom_range(1, L - 1) : -1;
        apply_stimulus(2'b00, up[0], L, 0);
        if (L == 0) begin
          check_output("rnd_run0", mv, 1, 0, 0);
        end else begin
          check("rnd_busy", int'(busy), 1);
          unheld = 0; cyc = 0; wraps = 0;
          while (unheld < L && cyc < 500) begin
            if (abort_at >= 0 && unheld == abort_at) break;
            hold = ($urandom_range(0, 3) == 0);
            tick();
            cyc++;
            if (!hold) unheld++;
            wraps += int'(wrap);
            check("rnd_done", int'(done), (unheld == L) ? 1 : 0);
          end
          hold = 0;
          if (abort_at >= 0) begin
            abort = 1;
            tick();
            abort = 0;
            steps = abort_at;
            check_output("rnd_abort", wrap_mod(up ? mv + steps : mv - steps), 0, 0, 1);
          end else begin
            steps = L;
            check("rnd_budget", int'(cyc < 500), 1);
            check_output("rnd_run", wrap_mod(up ? mv + steps : mv - steps), 1, 0, 0);
          end
          check("rnd_idle", int'(busy), 0);
          check("rnd_wraps", wraps, count_wraps(mv, up, steps));
          mv = wrap_mod(up ? mv + steps : mv - steps);
        end
      end else if (opsel < 8) begin
        d = $urandom_range(0, MOD - 1);
        apply_stimulus(2'b01, 1'b0, 0, d);
        mv = d;
        check_output("rnd_load", mv, 1, 0, 0);
      end else if (opsel == 8) begin
        apply_stimulus(2'b10, 1'b0, 0, 0);
        mv = 0;
        check_output("rnd_clear", mv, 1, 0, 0);
      end else begin
        apply_stimulus(2'b11, 1'b0, 0, $urandom_range(0, MOD - 1));
        check_output("rnd_rsvd", mv, 0, 1, 0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
